// File: rtl/pipeline_scoreboard.sv
// Hazard/forwarding controller for the in-order pipeline: tracks in-flight register writes
// per post-ID stage, picks per-source forwarding selects, raises ID stalls, counts events.
module pipeline_scoreboard #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned FWD_EN  = 1,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned SEL_W   = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     id_valid_i,
  input  logic [5*NUM_SRC-1:0]     id_src_num_i,
  input  logic [NUM_SRC-1:0]       id_src_used_i,
  input  logic [4:0]               id_dst_num_i,
  input  logic                     id_wr_en_i,
  input  logic                     id_is_load_i,
  input  logic                     flush_i,
  input  logic                     halt_i,
  output logic                     stall_o,
  output logic                     issue_o,
  output logic [SEL_W*NUM_SRC-1:0] fwd_sel_o,
  output logic [CNT_W-1:0]         perf_cycles_o,
  output logic [CNT_W-1:0]         perf_stalls_o,
  output logic [CNT_W-1:0]         perf_flushes_o
);

  // Index k holds stage k+1 (index 0 = EX, index DEPTH-1 = WB).
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] load_q, load_d;
  logic [4:0]       dst_q [DEPTH];
  logic [4:0]       dst_d [DEPTH];

  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] stalls_q, stalls_d;
  logic [CNT_W-1:0] flushes_q, flushes_d;

  logic hazard;

  always_comb begin
    logic [4:0] src;
    logic       hit;
    int         young;
    hazard    = 1'b0;
    fwd_sel_o = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src   = id_src_num_i[5*i +: 5];
      hit   = 1'b0;
      young = 0;
      // Scan oldest to youngest so the youngest match overwrites.
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (valid_q[k] && (dst_q[k] == src) && (dst_q[k] != 5'd0) &&
            id_src_used_i[i] && id_valid_i) begin
          hit   = 1'b1;
          young = k;
        end
      end
      if (hit) begin
        fwd_sel_o[SEL_W*i +: SEL_W] = SEL_W'(young + 1);
        if (FWD_EN != 0) begin
          if (young == 0 && load_q[0]) hazard = 1'b1;
        end else begin
          // The WB stage is served by register-file write-through.
          if (young < int'(DEPTH) - 1) hazard = 1'b1;
        end
      end
    end
  end

  assign stall_o = halt_i | (hazard & ~flush_i);
  assign issue_o = id_valid_i & ~stall_o & ~flush_i & ~halt_i;

  always_comb begin
    valid_d[0] = issue_o & id_wr_en_i & (id_dst_num_i != 5'd0);
    load_d[0]  = id_is_load_i;
    dst_d[0]   = id_dst_num_i;
    for (int k = 1; k < int'(DEPTH); k++) begin
      valid_d[k] = valid_q[k-1];
      load_d[k]  = load_q[k-1];
      dst_d[k]   = dst_q[k-1];
    end
  end

  always_comb begin
    cycles_d  = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
    stalls_d  = stalls_q;
    flushes_d = flushes_q;
    if (stall_o && stalls_q != '1)   stalls_d  = stalls_q + CNT_W'(1);
    if (flush_i && flushes_q != '1)  flushes_d = flushes_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      cycles_q  <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else if (!halt_i) begin
      valid_q   <= valid_d;
      cycles_q  <= cycles_d;
      stalls_q  <= stalls_d;
      flushes_q <= flushes_d;
    end
  end

  // Payload needs no reset; valid_q gates every use.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !halt_i) begin
      load_q <= load_d;
      dst_q  <= dst_d;
    end
  end

  assign perf_cycles_o  = cycles_q;
  assign perf_stalls_o  = stalls_q;
  assign perf_flushes_o = flushes_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench: default, stall-only and narrow-counter instances driven with shared inputs.
module tb_pipeline_scoreboard;

  typedef struct {
    logic       v;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] used;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
    logic       fl;
    logic       ht;
    logic       e_stall;
    logic       e_issue;
    logic [2:0] e_sel0;
    logic [2:0] e_sel1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [9:0] id_src_num;
  logic [1:0] id_src_used;
  logic [4:0] id_dst_num;
  logic       id_wr_en;
  logic       id_is_load;
  logic       flush;
  logic       halt;

  logic        stall_a, issue_a, stall_b, issue_b, stall_c, issue_c;
  logic [5:0]  sel_a, sel_b, sel_c;
  logic [31:0] cyc_a, stl_a, fl_a, cyc_b, stl_b, fl_b;
  logic [3:0]  cyc_c, stl_c, fl_c;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  pipeline_scoreboard u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_src_num_i(id_src_num),
    .id_src_used_i(id_src_used), .id_dst_num_i(id_dst_num), .id_wr_en_i(id_wr_en),
    .id_is_load_i(id_is_load), .flush_i(flush), .halt_i(halt), .stall_o(stall_a),
    .issue_o(issue_a), .fwd_sel_o(sel_a), .perf_cycles_o(cyc_a), .perf_stalls_o(stl_a),
    .perf_flushes_o(fl_a)
  );

  pipeline_scoreboard #(.FWD_EN(0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_src_num_i(id_src_num),
    .id_src_used_i(id_src_used), .id_dst_num_i(id_dst_num), .id_wr_en_i(id_wr_en),
    .id_is_load_i(id_is_load), .flush_i(flush), .halt_i(halt), .stall_o(stall_b),
    .issue_o(issue_b), .fwd_sel_o(sel_b), .perf_cycles_o(cyc_b), .perf_stalls_o(stl_b),
    .perf_flushes_o(fl_b)
  );

  pipeline_scoreboard #(.CNT_W(4)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_src_num_i(id_src_num),
    .id_src_used_i(id_src_used), .id_dst_num_i(id_dst_num), .id_wr_en_i(id_wr_en),
    .id_is_load_i(id_is_load), .flush_i(flush), .halt_i(halt), .stall_o(stall_c),
    .issue_o(issue_c), .fwd_sel_o(sel_c), .perf_cycles_o(cyc_c), .perf_stalls_o(stl_c),
    .perf_flushes_o(fl_c)
  );

  function automatic vec_t mk(input int v, s0, s1, used, dst, wr, ld, fl, ht,
                              es, ei, e0, e1);
    vec_t t;
    t.v = 1'(v); t.s0 = 5'(s0); t.s1 = 5'(s1); t.used = 2'(used); t.dst = 5'(dst);
    t.wr = 1'(wr); t.ld = 1'(ld); t.fl = 1'(fl); t.ht = 1'(ht);
    t.e_stall = 1'(es); t.e_issue = 1'(ei); t.e_sel0 = 3'(e0); t.e_sel1 = 3'(e1);
    return t;
  endfunction

  task automatic drive(input vec_t t);
    id_valid    = t.v;
    id_src_num  = {t.s1, t.s0};
    id_src_used = t.used;
    id_dst_num  = t.dst;
    id_wr_en    = t.wr;
    id_is_load  = t.ld;
    flush       = t.fl;
    halt        = t.ht;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  vec_t tbl[15];

  initial begin
    // Default config (DEPTH=3, forwarding on), one row per cycle from reset.
    tbl[0]  = mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0, 0);  // add $3
    tbl[1]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);  // $3 in EX
    tbl[2]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0);  // $3 in MEM
    tbl[3]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0);  // $3 in WB
    tbl[4]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);  // retired
    tbl[5]  = mk(1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1, 0, 0);  // lw $5
    tbl[6]  = mk(1, 0, 5, 2, 0, 0, 0, 0, 0, 1, 0, 0, 1);  // load-use stall
    tbl[7]  = mk(1, 0, 5, 2, 0, 0, 0, 0, 0, 0, 1, 0, 2);  // forwarded from MEM
    tbl[8]  = mk(1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0);  // add $4
    tbl[9]  = mk(0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // invalid ID never matches
    tbl[10] = mk(1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0);  // add $4 again
    tbl[11] = mk(1, 4, 4, 3, 0, 0, 0, 0, 0, 0, 1, 1, 1);  // youngest wins
    tbl[12] = mk(1, 4, 4, 2, 0, 1, 0, 0, 0, 0, 1, 0, 2);  // src0 unused; writes $0
    tbl[13] = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0);  // $0 never matches
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    rst_n = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    do_reset();
    chk("reset stall", 32'(stall_a), 0);
    chk("reset sel", 32'(sel_a), 0);
    chk("reset cycles", cyc_a, 0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d stall", i), 32'(stall_a), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d issue", i), 32'(issue_a), 32'(tbl[i].e_issue));
      chk($sformatf("vec%0d fwd_sel", i), 32'(sel_a), 32'({tbl[i].e_sel1, tbl[i].e_sel0}));
      cycle();
    end
    chk("table perf_cycles", cyc_a, 15);
    chk("table perf_stalls", stl_a, 1);
    chk("table perf_flushes", fl_a, 0);

    // Stall-only mode: consumer of $7 waits DEPTH-1 cycles.
    do_reset();
    drive(mk(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("nofwd producer issue", 32'(issue_b), 1);
    cycle();
    drive(mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("nofwd c1 stall", 32'(stall_b), 1);
    chk("nofwd c1 sel", 32'(sel_b), 1);
    chk("fwd c1 stall", 32'(stall_a), 0);
    cycle();
    chk("nofwd c2 stall", 32'(stall_b), 1);
    chk("nofwd c2 sel", 32'(sel_b), 2);
    cycle();
    chk("nofwd c3 stall", 32'(stall_b), 0);
    chk("nofwd c3 issue", 32'(issue_b), 1);
    chk("nofwd c3 sel", 32'(sel_b), 3);
    cycle();
    chk("nofwd perf_stalls", stl_b, 2);

    // Flush overrides a load-use hazard and leaves a bubble in EX.
    do_reset();
    drive(mk(1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
    cycle();
    drive(mk(1, 0, 5, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    #1;
    chk("flush stall", 32'(stall_a), 0);
    chk("flush issue", 32'(issue_a), 0);
    cycle();
    drive(mk(1, 0, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("post-flush stall", 32'(stall_a), 0);
    chk("post-flush sel", 32'(sel_a), 32'({3'd2, 3'd0}));
    chk("post-flush issue", 32'(issue_a), 1);
    chk("flush perf_flushes", fl_a, 1);
    chk("flush perf_stalls", stl_a, 0);

    // Halt freezes a load in EX; reset then wipes everything.
    do_reset();
    drive(mk(1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
    cycle();
    drive(mk(1, 5, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("halt%0d stall", i), 32'(stall_a), 1);
      chk($sformatf("halt%0d issue", i), 32'(issue_a), 0);
      chk($sformatf("halt%0d sel", i), 32'(sel_a), 1);
      cycle();
    end
    chk("halt perf_cycles", cyc_a, 1);
    chk("halt perf_stalls", stl_a, 0);
    halt = 1'b0;
    #1 chk("unhalt load-use stall", 32'(stall_a), 1);
    rst_n = 1'b0;
    cycle();
    chk("rst perf_cycles", cyc_a, 0);
    chk("rst perf_stalls", stl_a, 0);
    chk("rst perf_flushes", fl_a, 0);
    chk("rst stall", 32'(stall_a), 0);
    chk("rst sel", 32'(sel_a), 0);
    chk("rst issue", 32'(issue_a), 1);
    rst_n = 1'b1;

    // 4-bit counter saturates at 15.
    do_reset();
    repeat (20) cycle();
    chk("sat perf_cycles", 32'(cyc_c), 15);
    chk("wide perf_cycles", cyc_a, 20);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
